// File: rtl/branch_trace_sequencer_if.sv
// Record-in and predictor handshake bundle for branch_trace_sequencer.
// master = sequencer view, slave = environment view (trace source + predictor).
interface branch_trace_sequencer_if;
    logic       rec_valid;
    logic [7:0] rec_addr;
    logic       rec_dir;
    logic       rec_ready;
    logic       new_data_avail;
    logic [7:0] inst_lowest_byte;
    logic       direction_ground_truth;
    logic       pred_ready;
    logic       prediction;
    logic       training_done;
    logic       mem_reset_done;

    modport master (
        input  rec_valid, rec_addr, rec_dir,
        input  pred_ready, prediction, training_done, mem_reset_done,
        output rec_ready, new_data_avail, inst_lowest_byte, direction_ground_truth
    );

    modport slave (
        output rec_valid, rec_addr, rec_dir,
        output pred_ready, prediction, training_done, mem_reset_done,
        input  rec_ready, new_data_avail, inst_lowest_byte, direction_ground_truth
    );
endinterface

// File: rtl/branch_trace_sequencer.sv
// Buffers branch trace records and feeds them one at a time to a perceptron-style predictor.
// Optional predictor-response timeout with sticky error state: define SEQ_TIMEOUT_EN.
module branch_trace_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    branch_trace_sequencer_if.master        bus,
    output logic                            busy,
    output logic [15:0]                     branch_count,
    output logic [15:0]                     mispredict_count,
    output logic                            err
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
        $error("branch_trace_sequencer: parameter out of range");
    end

`ifdef SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {WAIT_MEM, IDLE, ISSUE, TRAIN, GAP, ERR} state_t;
`else
    typedef enum logic [2:0] {WAIT_MEM, IDLE, ISSUE, TRAIN, GAP} state_t;
`endif

    state_t state, state_next;

    logic [8:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop, respond;

    // Ready reflects the registered fill level, so a same-cycle pop never opens the door early.
    assign bus.rec_ready = (count != FULL_CNT);
    assign push          = bus.rec_valid && bus.rec_ready;
    assign pop           = (state == IDLE) && (count != '0);
    assign respond       = (state == ISSUE) && bus.pred_ready;

    // NOTE: the storage array is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.rec_addr, bus.rec_dir};
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
    logic       timeout;

    assign timeout = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state && (state_next == ISSUE || state_next == TRAIN)) begin
            wait_cnt <= '0;
        end else if ((state == ISSUE || state == TRAIN) && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_MEM;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            WAIT_MEM: if (bus.mem_reset_done) state_next = IDLE;
            IDLE:     if (count != '0)        state_next = ISSUE;
            ISSUE: begin
                if (bus.pred_ready)  state_next = bus.training_done ? GAP : TRAIN;
`ifdef SEQ_TIMEOUT_EN
                else if (timeout)    state_next = ERR;
`endif
            end
            TRAIN: begin
                if (bus.training_done) state_next = GAP;
`ifdef SEQ_TIMEOUT_EN
                else if (timeout)      state_next = ERR;
`endif
            end
            GAP:      state_next = IDLE;
            default:  state_next = state;
        endcase
    end

    always_comb begin
        bus.new_data_avail = 1'b0;
        busy               = 1'b0;
        err                = 1'b0;
        case (state)
            ISSUE, TRAIN: begin
                bus.new_data_avail = 1'b1;
                busy               = 1'b1;
            end
            GAP:     busy = 1'b1;
`ifdef SEQ_TIMEOUT_EN
            ERR:     err  = 1'b1;
`endif
            default: ;
        endcase
    end

    // Issue registers hold the popped record until the next pop; counters saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.inst_lowest_byte       <= '0;
            bus.direction_ground_truth <= 1'b0;
            branch_count               <= '0;
            mispredict_count           <= '0;
        end else begin
            if (pop) {bus.inst_lowest_byte, bus.direction_ground_truth} <= fifo_mem[rd_ptr];
            if (respond) begin
                if (branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
                if (bus.prediction != bus.direction_ground_truth && mispredict_count != 16'hFFFF)
                    mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_trace_sequencer.sv
// Directed scoreboard bench for branch_trace_sequencer; timeout checks run when SEQ_TIMEOUT_EN is defined.
module tb_branch_trace_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;
    logic        err;

    branch_trace_sequencer_if bus();

    branch_trace_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.master),
        .busy             (busy),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic       dir;
    } rec_t;

    rec_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_branch = '0;
    logic [15:0] exp_mis    = '0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_ready();
        bus.mem_reset_done = 1'b1;
        tick();
        bus.mem_reset_done = 1'b0;
    endtask

    task automatic push_rec(input logic [7:0] addr, input logic dir);
        int n = 0;
        bus.rec_valid = 1'b1;
        bus.rec_addr  = addr;
        bus.rec_dir   = dir;
        while (!bus.rec_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", bus.rec_ready, 1);
        if (bus.rec_ready) sb.push_back('{addr: addr, dir: dir});
        tick();
        bus.rec_valid = 1'b0;
    endtask

    // Waits for an issue, checks it against the scoreboard, answers as the predictor, ends in GAP.
    task automatic serve(input logic pred, input logic td_same);
        int   n = 0;
        rec_t e_rec = '0;
        while (!bus.new_data_avail && n < 100) begin
            tick();
            n++;
        end
        check("nda_rise", bus.new_data_avail, 1);
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) e_rec = sb.pop_front();
        check("issue_addr", bus.inst_lowest_byte, e_rec.addr);
        check("issue_dir", bus.direction_ground_truth, e_rec.dir);
        check("issue_busy", busy, 1);
        check("issue_err", err, 0);
        bus.pred_ready    = 1'b1;
        bus.prediction    = pred;
        bus.training_done = td_same;
        tick();
        if (exp_branch != 16'hFFFF) exp_branch++;
        if (pred != e_rec.dir && exp_mis != 16'hFFFF) exp_mis++;
        if (!td_same) begin
            check("train_nda", bus.new_data_avail, 1);
            tick();
            check("train_ignores_pred", branch_count, exp_branch);
            bus.pred_ready    = 1'b0;
            bus.training_done = 1'b1;
            tick();
        end
        bus.pred_ready    = 1'b0;
        bus.training_done = 1'b0;
        check("gap_nda_low", bus.new_data_avail, 0);
        check("gap_busy", busy, 1);
        check("branch_count", branch_count, exp_branch);
        check("mispredict_count", mispredict_count, exp_mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n;

        rst                = 1'b1;
        bus.rec_valid      = 1'b0;
        bus.rec_addr       = '0;
        bus.rec_dir        = 1'b0;
        bus.pred_ready     = 1'b0;
        bus.prediction     = 1'b0;
        bus.training_done  = 1'b0;
        bus.mem_reset_done = 1'b0;
        #8;
        check("rst_rec_ready", bus.rec_ready, 1);
        check("rst_nda", bus.new_data_avail, 0);
        check("rst_addr", bus.inst_lowest_byte, 0);
        check("rst_dir", bus.direction_ground_truth, 0);
        check("rst_busy", busy, 0);
        check("rst_branch", branch_count, 0);
        check("rst_mis", mispredict_count, 0);
        check("rst_err", err, 0);
        #14 rst = 1'b0;
        tick();

        // Nothing issues while the predictor memory is still clearing.
        push_rec(8'h3C, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.new_data_avail) seen = 1'b1;
            tick();
        end
        check("nda_before_mem_done", seen, 0);
        check("busy_wait_mem", busy, 0);
        mem_ready();
        check("idle_nda", bus.new_data_avail, 0);
        tick();
        check("first_issue_nda", bus.new_data_avail, 1);
        check("first_issue_addr", bus.inst_lowest_byte, 8'h3C);
        serve(1'b1, 1'b0);
        tick();

        // Push-to-issue latency from an empty FIFO, then three predictions (one wrong).
        push_rec(8'h10, 1'b1);
        check("latency_nda_low", bus.new_data_avail, 0);
        push_rec(8'h11, 1'b1);
        check("latency_nda_high", bus.new_data_avail, 1);
        push_rec(8'h12, 1'b1);
        serve(1'b1, 1'b0);
        serve(1'b0, 1'b0);
        serve(1'b1, 1'b0);
        tick();

        // Prediction and training completion on the same edge.
        push_rec(8'h50, 1'b0);
        push_rec(8'h51, 1'b1);
        serve(1'b0, 1'b1);
        tick();
        check("gap_to_idle_nda", bus.new_data_avail, 0);
        check("idle_busy", busy, 0);
        tick();
        check("reissue_nda", bus.new_data_avail, 1);
        serve(1'b1, 1'b1);
        tick();

        // Stalled predictor: one record in flight, four buffered, the next held back.
        push_rec(8'h60, 1'b1);
        push_rec(8'h61, 1'b0);
        push_rec(8'h62, 1'b1);
        push_rec(8'h63, 1'b0);
        push_rec(8'h64, 1'b1);
        check("full_rec_ready", bus.rec_ready, 0);
        bus.rec_valid = 1'b1;
        bus.rec_addr  = 8'h68;
        bus.rec_dir   = 1'b0;
        tick();
        tick();
        check("held_rec_ready", bus.rec_ready, 0);
        serve(1'b0, 1'b0);
        tick();
        check("idle_still_full", bus.rec_ready, 0);
        tick();
        check("after_pop_ready", bus.rec_ready, 1);
        check("after_pop_nda", bus.new_data_avail, 1);
        tick();
        sb.push_back('{addr: 8'h68, dir: 1'b0});
        bus.rec_valid = 1'b0;
        serve(1'b0, 1'b0);
        serve(1'b0, 1'b1);
        serve(1'b1, 1'b0);
        serve(1'b1, 1'b1);
        serve(1'b0, 1'b0);
        tick();

        // Asynchronous reset mid-transaction drops the transaction uncounted.
        push_rec(8'h70, 1'b1);
        n = 0;
        while (!bus.new_data_avail && n < 20) begin
            tick();
            n++;
        end
        check("pre_reset_nda", bus.new_data_avail, 1);
        bus.pred_ready = 1'b1;
        bus.prediction = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_nda", bus.new_data_avail, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_branch", branch_count, 0);
        check("async_rst_mis", mispredict_count, 0);
        check("async_rst_addr", bus.inst_lowest_byte, 0);
        bus.pred_ready = 1'b0;
        sb.delete();
        exp_branch = '0;
        exp_mis    = '0;
        #5 rst = 1'b0;
        tick();
        mem_ready();

`ifdef SEQ_TIMEOUT_EN
        push_rec(8'h77, 1'b1);
        n = 0;
        while (!bus.new_data_avail && n < 20) begin
            tick();
            n++;
        end
        check("to_issue_nda", bus.new_data_avail, 1);
        n = 0;
        while (!err && n < 400) begin
            tick();
            n++;
        end
        check("to_cycles", n, 255);
        check("to_err", err, 1);
        check("to_nda", bus.new_data_avail, 0);
        check("to_busy", busy, 0);
        check("to_branch", branch_count, exp_branch);
        check("to_mis", mispredict_count, exp_mis);
        #2 rst = 1'b1;
        #1;
        check("to_rst_err", err, 0);
        sb.delete();
        #5 rst = 1'b0;
        tick();
        mem_ready();
`endif

        // Saturation of the mispredict counter.
        push_rec(8'h7F, 1'b1);
        force dut.mispredict_count = 16'hFFFF;
        #1 release dut.mispredict_count;
        exp_mis = 16'hFFFF;
        check("forced_mis", mispredict_count, 16'hFFFF);
        serve(1'b0, 1'b0);
        tick();
        check("sat_branch_final", branch_count, exp_branch);
        check("sb_drained", sb.size(), 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
